// File: rtl/external_bus_target_pkg.sv
// Shared types and encodings for the external bus target: header layout,
// transfer size codes and the default burst length.
package external_bus_target_pkg;

  // 64-byte cache line of 32-bit words -> 16 beats per burst
  localparam int unsigned BURST_LOG2_DEF = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_LINE = 2'd3;

  typedef struct packed {
    logic        is_write;
    logic [1:0]  size;
    logic [28:0] addr;
  } ext_bus_hdr_t;

endpackage

// File: rtl/ext_bus_rd_fifo.sv
// Two-entry read-return FIFO between the memory port and the bus.
// Supports simultaneous push and pop when full, preserving ordering.
module ext_bus_rd_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/external_bus_target.sv
// Responder end of the narrow external bus: decodes the header word and runs
// single MMIO or wrapped cache-line bursts against an SRAM-style memory port.
module external_bus_target
  import external_bus_target_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_LEN   = 29,
  parameter int unsigned BURST_LOG2 = BURST_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      IN_bus,
  output logic [WIDTH-1:0]      OUT_bus,
  output logic                  OUT_busOE,
  input  logic                  IN_busValid,
  output logic                  OUT_busReady,
  output logic                  OUT_memCe,
  output logic                  OUT_memWe,
  output logic [ADDR_LEN-3:0]   OUT_memAddr,
  output logic [WIDTH-1:0]      OUT_memWdata,
  output logic [WIDTH/8-1:0]    OUT_memWmask,
  input  logic [WIDTH-1:0]      IN_memRdata,
  input  logic                  IN_memBusy
);

  localparam int unsigned CW = BURST_LOG2 + 1;
  localparam int unsigned MW = WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t                state_q, state_nx;
  ext_bus_hdr_t          hdr;
  logic                  alive_q;
  logic [1:0]            size_q;
  logic [ADDR_LEN-1:0]   addr_q;
  logic [ADDR_LEN-1:0]   addr_nx;
  logic [BURST_LOG2-1:0] idx_nx;
  logic [CW-1:0]         beats_q, done_q, issued_q;
  logic                  inflight_q;
  logic                  beat, mem_acc, last, issue_ok;
  logic [WIDTH-1:0]      fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [1:0]            fifo_count;

  assign hdr     = ext_bus_hdr_t'(IN_bus);
  assign beat    = IN_busValid && OUT_busReady;
  assign mem_acc = OUT_memCe && !IN_memBusy;
  assign last    = (done_q + CW'(1)) == beats_q;

  // Burst word index wraps inside the line; upper address bits are held
  assign idx_nx  = addr_q[BURST_LOG2+1:2] + BURST_LOG2'(1);
  assign addr_nx = {addr_q[ADDR_LEN-1:BURST_LOG2+2], idx_nx, addr_q[1:0]};

  // Fifo occupancy plus the in-flight read never exceeds the two slots
  assign issue_ok = (state_q == S_READ) && (issued_q < beats_q) && !fifo_full &&
                    ((3'(fifo_count) + 3'(inflight_q)) < 3'd2);

  assign OUT_memAddr  = addr_q[ADDR_LEN-1:2];
  assign OUT_memWdata = IN_bus;
  assign OUT_bus      = OUT_busOE ? fifo_head : '0;

  always_comb begin
    case (size_q)
      SZ_BYTE: OUT_memWmask = MW'(1) << addr_q[1:0];
      SZ_HALF: OUT_memWmask = MW'(3) << {addr_q[1], 1'b0};
      default: OUT_memWmask = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx     = state_q;
    OUT_busOE    = 1'b0;
    OUT_busReady = 1'b0;
    OUT_memCe    = 1'b0;
    OUT_memWe    = 1'b0;
    case (state_q)
      S_IDLE: begin
        OUT_busReady = alive_q;
        if (IN_busValid && alive_q) state_nx = hdr.is_write ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        OUT_busReady = !IN_memBusy;
        OUT_memCe    = IN_busValid;
        OUT_memWe    = 1'b1;
        if (IN_busValid && !IN_memBusy && last) state_nx = S_IDLE;
      end
      S_READ: begin
        OUT_busOE    = 1'b1;
        OUT_busReady = !fifo_empty;
        OUT_memCe    = issue_ok;
        if (IN_busValid && !fifo_empty && last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Header latch, beat counters and the read-issue bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      beats_q    <= '0;
      done_q     <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      alive_q    <= 1'b1;
      inflight_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (beat) begin
            size_q   <= hdr.size;
            addr_q   <= (hdr.size == SZ_LINE) ? ADDR_LEN'({hdr.addr[28:2], 2'b00})
                                              : ADDR_LEN'(hdr.addr);
            beats_q  <= (hdr.size == SZ_LINE) ? (CW'(1) << BURST_LOG2) : CW'(1);
            done_q   <= '0;
            issued_q <= '0;
          end
        end
        S_WRITE: begin
          if (beat) begin
            done_q <= done_q + CW'(1);
            addr_q <= addr_nx;
          end
        end
        S_READ: begin
          inflight_q <= mem_acc;
          if (mem_acc) begin
            issued_q <= issued_q + CW'(1);
            addr_q   <= addr_nx;
          end
          if (beat) done_q <= done_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  ext_bus_rd_fifo #(.WIDTH(WIDTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (IN_memRdata),
    .pop       ((state_q == S_READ) && beat),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_external_bus_target.sv
// Scoreboard bench for external_bus_target: behavioural SRAM model, expected
// read data / addresses / write beats queued at stimulus time and popped on DUT activity.
module tb_external_bus_target;

  logic        clk;
  logic        rst;
  logic [31:0] IN_bus;
  logic [31:0] OUT_bus;
  logic        OUT_busOE;
  logic        IN_busValid;
  logic        OUT_busReady;
  logic        OUT_memCe;
  logic        OUT_memWe;
  logic [26:0] OUT_memAddr;
  logic [31:0] OUT_memWdata;
  logic [3:0]  OUT_memWmask;
  logic [31:0] IN_memRdata;
  logic        IN_memBusy;

  int n_checks;
  int n_errors;
  int acc_rd;
  int del_rd;
  logic        hold_pend;
  logic [31:0] hold_val;

  logic [31:0] mem [0:2047];
  logic [31:0] exp_rd_q [$];
  logic [26:0] exp_ra_q [$];
  logic [63:0] exp_wr_q [$];

  external_bus_target dut (
    .clk          (clk),
    .rst          (rst),
    .IN_bus       (IN_bus),
    .OUT_bus      (OUT_bus),
    .OUT_busOE    (OUT_busOE),
    .IN_busValid  (IN_busValid),
    .OUT_busReady (OUT_busReady),
    .OUT_memCe    (OUT_memCe),
    .OUT_memWe    (OUT_memWe),
    .OUT_memAddr  (OUT_memAddr),
    .OUT_memWdata (OUT_memWdata),
    .OUT_memWmask (OUT_memWmask),
    .IN_memRdata  (IN_memRdata),
    .IN_memBusy   (IN_memBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (OUT_memCe && !IN_memBusy) begin
      if (OUT_memWe) begin
        for (int b = 0; b < 4; b++)
          if (OUT_memWmask[b]) mem[OUT_memAddr[10:0]][8*b +: 8] = OUT_memWdata[8*b +: 8];
      end else begin
        IN_memRdata <= mem[OUT_memAddr[10:0]];
      end
    end
  end

  // Monitor: pops scoreboard entries as the DUT delivers data or touches memory
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1 && OUT_busOE) begin
      check("outstanding_le2", 64'((acc_rd - del_rd) <= 2), 64'd1);
      if (hold_pend && OUT_busReady) check("rd_hold_stable", 64'(OUT_bus), 64'(hold_val));
      hold_pend = OUT_busReady && !IN_busValid;
      hold_val  = OUT_bus;
      if (IN_busValid && OUT_busReady) begin
        check("rd_expected", 64'(exp_rd_q.size() > 0), 64'd1);
        if (exp_rd_q.size() > 0) check("rd_data", 64'(OUT_bus), 64'(exp_rd_q.pop_front()));
        del_rd++;
      end
    end else begin
      hold_pend = 1'b0;
    end
    if (rst === 1'b1 && OUT_memCe && !IN_memBusy) begin
      if (OUT_memWe) begin
        check("wr_expected", 64'(exp_wr_q.size() > 0), 64'd1);
        if (exp_wr_q.size() > 0)
          check("wr_beat", {1'b0, OUT_memAddr, OUT_memWmask, OUT_memWdata}, exp_wr_q.pop_front());
      end else begin
        check("ra_expected", 64'(exp_ra_q.size() > 0), 64'd1);
        if (exp_ra_q.size() > 0) check("rd_addr", 64'(OUT_memAddr), 64'(exp_ra_q.pop_front()));
        acc_rd++;
      end
    end
  end

  task automatic do_read(input logic [31:0] hdr, input int vmode, input int bmode,
                         input int abort_at);
    int n, cyc, start, acc0;
    logic [26:0] base, w;
    n    = (hdr[30:29] == 2'b11) ? 16 : 1;
    base = hdr[28:2];
    for (int i = 0; i < n; i++) begin
      w = (n == 16) ? ((base & ~27'hF) | ((base + 27'(i)) & 27'hF)) : base;
      exp_ra_q.push_back(w);
      exp_rd_q.push_back(mem[w[10:0]]);
    end
    start = del_rd;
    acc0  = acc_rd;
    cyc   = 0;
    @(negedge clk);
    IN_bus = hdr; IN_busValid = 1'b1; IN_memBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (del_rd - start == n) break;
      if (abort_at > 0 && del_rd - start == abort_at) begin
        rst = 1'b0; IN_busValid = 1'b0; IN_memBusy = 1'b0;
        #1;
        check("rst_async_oe_rdy_ce", 64'({OUT_busOE, OUT_busReady, OUT_memCe}), 64'd0);
        check("rst_async_bus", 64'(OUT_bus), 64'd0);
        exp_rd_q.delete(); exp_ra_q.delete();
        acc_rd = 0; del_rd = 0; hold_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      if (cyc > 400) begin
        check("rd_timeout", 64'(del_rd - start), 64'(n));
        break;
      end
      cyc++;
      IN_bus      = '0;
      IN_busValid = (vmode == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
      IN_memBusy  = (bmode != 0) && (cyc % 5 == 2);
    end
    IN_busValid = 1'b0; IN_memBusy = 1'b0;
    #2;
    check("rd_issue_count", 64'(acc_rd - acc0), 64'(n));
    check("rd_done_idle", 64'({OUT_busOE, OUT_busReady}), 64'b01);
  endtask

  task automatic do_write(input logic [31:0] hdr, input logic [31:0] d0,
                          input int stall_lo, input int stall_hi);
    int n, i, cyc, stall;
    logic [26:0] base, w;
    logic [3:0]  m;
    logic [1:0]  a;
    n    = (hdr[30:29] == 2'b11) ? 16 : 1;
    base = hdr[28:2];
    a    = hdr[1:0];
    case (hdr[30:29])
      2'd0:    m = 4'b0001 << a;
      2'd1:    m = 4'b0011 << {a[1], 1'b0};
      default: m = 4'b1111;
    endcase
    for (int k = 0; k < n; k++) begin
      w = (n == 16) ? ((base & ~27'hF) | ((base + 27'(k)) & 27'hF)) : base;
      exp_wr_q.push_back({1'b0, w, m, d0 + 32'(k)});
    end
    @(negedge clk);
    IN_bus = hdr; IN_busValid = 1'b1; IN_memBusy = 1'b0;
    i = 0; cyc = 0; stall = 0;
    forever begin
      @(negedge clk);
      if (i == n) break;
      if (cyc > 200) begin
        check("wr_timeout", 64'(i), 64'(n));
        break;
      end
      cyc++;
      IN_bus      = d0 + 32'(i);
      IN_busValid = 1'b1;
      IN_memBusy  = (i >= stall_lo) && (i <= stall_hi) && (stall < 2);
      #1;
      if (IN_memBusy) begin
        stall++;
        check("wr_stall_ready", 64'(OUT_busReady), 64'd0);
      end else begin
        check("wr_ready", 64'(OUT_busReady), 64'd1);
        stall = 0;
        i++;
      end
    end
    IN_busValid = 1'b0; IN_memBusy = 1'b0; IN_bus = '0;
    #2;
    check("wr_done_idle", 64'({OUT_busOE, OUT_busReady}), 64'b01);
    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; acc_rd = 0; del_rd = 0; hold_pend = 1'b0; hold_val = '0;
    rst = 1'b0; IN_bus = '0; IN_busValid = 1'b0; IN_memBusy = 1'b0;
    for (int k = 0; k < 2048; k++) mem[k] = 32'h0;
    mem[0] = 32'h1122_3344;
    mem[1] = 32'h5555_5555;
    mem[11'h400] = 32'hDEAD_BEEF;
    for (int k = 16; k < 32; k++) mem[k] = 32'h100 + 32'(k);

    repeat (2) @(negedge clk);
    #1;
    check("reset_oe_rdy_ce", 64'({OUT_busOE, OUT_busReady, OUT_memCe}), 64'd0);
    check("reset_bus", 64'(OUT_bus), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_ready", 64'({OUT_busOE, OUT_busReady}), 64'b01);

    do_read(32'h0000_1000, 0, 0, 0);
    do_write(32'h8000_0003, 32'hAA00_0000, -1, -2);
    check("mem_byte_write", 64'(mem[0]), 64'hAA22_3344);
    do_write(32'hA000_0006, 32'h5678_0000, -1, -2);
    check("mem_half_write", 64'(mem[1]), 64'h5678_5555);
    do_write(32'hC000_0010, 32'hCAFE_F00D, -1, -2);
    check("mem_word_write", 64'(mem[4]), 64'hCAFE_F00D);

    for (int k = 0; k < 16; k++) mem[k] = 32'(k);
    do_read(32'h6000_0038, 0, 0, 0);
    do_read(32'h6000_0044, 1, 1, 0);
    do_write(32'hE000_0080, 32'h0000_5000, 3, 5);
    for (int k = 0; k < 16; k++) check("mem_line_write", 64'(mem[32 + k]), 64'(32'h5000 + 32'(k)));

    do_read(32'h6000_0000, 0, 0, 7);
    check("post_reset_idle", 64'({OUT_busOE, OUT_busReady, OUT_memCe}), 64'b010);
    do_read(32'h0000_1000, 0, 0, 0);
    do_read(32'h6000_0044, 1, 1, 0);

    check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    check("ra_queue_empty", 64'(exp_ra_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
